rx_bit_timer: RTL
=================

Name: rx_bit_timer

Overview:
- USB receive bit-timing stage, directly downstream of the edge detector.
- Consumes the `d_edge` pulse to lock to, and re-synchronise on, incoming bit boundaries.
- Emits one `shift_enable` strobe per bit at a fixed sample point inside the bit window.
- Tracks bits per byte and pulses `byte_received` when a full data byte has been shifted; feeds the RX shift register and the RX control FSM.

Parameters:
- CLKS_PER_BIT, 8, system clocks per USB bit period; must be >= 4.
- SAMPLE_POINT, 3, clk_cnt value at which the bit is sampled; 1 <= SAMPLE_POINT < CLKS_PER_BIT.
- BITS_PER_BYTE, 8, data bits counted per byte.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- d_edge  input  1  one-cycle pulse from edge detector, marking a line transition (bit boundary).
- rcving  input  1  high while the RX controller is receiving a packet.
- skip_bit  input  1  high with shift_enable when the current bit is a stuffed bit. It is then excluded from the byte count.
- shift_enable  output  1  one-cycle strobe at the bit sample point.
- byte_received  output  1  one-cycle pulse after the last counted bit of a byte.
- bit_cnt  output  $clog2(BITS_PER_BYTE)+1  counted bits in the current byte, 0..BITS_PER_BYTE-1.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, clk_cnt=0, bit_cnt=0, byte_received=0. shift_enable=0 by decode. rst overrides every other input.
- State IDLE:
  - Counters held at 0; d_edge ignored.
  - rcving=1 -> WAIT_EDGE next cycle.
- State WAIT_EDGE:
  - Counters held at 0.
  - d_edge=1 -> RUN with clk_cnt=1 next cycle. The edge cycle counts as cycle 0 of the bit.
  - rcving=0 -> IDLE.
- State RUN:
  - clk_cnt increments each cycle and wraps CLKS_PER_BIT-1 -> 0.
  - d_edge=1 in any RUN cycle -> clk_cnt=1 next cycle (resync). Resync has priority over increment and wrap.
- rcving=0 in WAIT_EDGE or RUN:
  - Next state IDLE; clk_cnt and bit_cnt cleared next cycle.
  - shift_enable is suppressed in that same cycle.
  - No byte_received is generated for a partial byte.
- shift_enable = (state==RUN) && rcving && (clk_cnt==SAMPLE_POINT). Moore decode of registered state, no added latency.
  - A d_edge coincident with clk_cnt==SAMPLE_POINT still yields shift_enable in that cycle, then resyncs.
- Bit counting, on shift_enable && !skip_bit:
  - If bit_cnt==BITS_PER_BYTE-1: bit_cnt wraps to 0 and byte_received is registered high the next cycle, for exactly one cycle.
  - Otherwise bit_cnt increments.
  - shift_enable && skip_bit: bit_cnt unchanged, no byte_received.
- Latency:
  - d_edge in cycle N (from WAIT_EDGE or RUN) -> first shift_enable in cycle N+SAMPLE_POINT.
  - Absent further edges, subsequent strobes every CLKS_PER_BIT cycles.
- Counter widths:
  - clk_cnt: $clog2(CLKS_PER_BIT) bits.
  - bit_cnt: $clog2(BITS_PER_BYTE)+1 bits.
  - All comparisons use unsigned values of equal width; no overflow beyond the stated wrap points.
- byte_received is cleared by rst or rcving=0 only if still pending. A pulse already registered is delivered; rcving=0 never truncates a pulse.

Decomposition:
- Shared package rx_pkg:
  - Enum rx_timer_state_t {IDLE, WAIT_EDGE, RUN}.
  - Constants USB_CLKS_PER_BIT=8, USB_SAMPLE_POINT=3, USB_BITS_PER_BYTE=8.
- One sub-module, sync_flex_counter:
  - Parameterised width.
  - Inputs: clear, count_enable, load with load_val, rollover_val.
  - Output: rollover_flag.
  - Synchronous active-high reset.
  - Instantiated twice: clk_cnt, with load used for resync, and bit_cnt.
- FSM and output decode stay in rx_bit_timer.

Test Plan:
1. rst=1 for 2 cycles with rcving=1 and d_edge toggling -> shift_enable=0, byte_received=0, bit_cnt=0 throughout; state IDLE after release.
2. rcving=1, single d_edge in cycle 10 -> shift_enable only in cycles 13, 21, 29, 37...; no strobe before cycle 13.
3. rcving=1, d_edge every 8 cycles from cycle 10, skip_bit=0 -> bit_cnt goes 1..7 then 0 on the 8th strobe (cycle 69); byte_received high in cycle 70 only.
4. Same as 3 with skip_bit=1 on the 4th strobe -> byte_received delayed to the cycle after the 9th strobe (cycle 78); bit_cnt holds 3 across the skipped strobe.
5. RUN with clk_cnt=6, d_edge in cycle N -> no strobe in N..N+2, strobe in N+3. Also: d_edge when clk_cnt=3 -> strobe in that cycle and again in cycle +3.
6. rcving drops after 5 counted bits -> next cycle IDLE, bit_cnt=0, no byte_received; new rcving+d_edge restarts cleanly, counting from bit 0.

Source files
------------

// File: rtl/rx_pkg.sv
// -----------------------------------------------------------------------------
// rx_pkg
//   Shared types and constants for the USB receive path.
//
//   rx_timer_state_t : bit-timer FSM states (IDLE, WAIT_EDGE, RUN)
//   rx_timer_dbg_t   : debug view of the bit timer (FSM state + bit-window wrap)
//   USB_*            : default timing constants for full-speed receive
// -----------------------------------------------------------------------------
package rx_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,  // not receiving; counters parked at zero
    WAIT_EDGE = 2'd1,  // receiving, waiting for the first bit boundary
    RUN       = 2'd2   // locked to bit boundaries, strobing each bit
  } rx_timer_state_t;

  // Debug view so checkers can observe the timer without reaching into it.
  typedef struct packed {
    rx_timer_state_t state;     // current FSM state
    logic            clk_wrap;  // clk_cnt sits at the last cycle of a bit window
  } rx_timer_dbg_t;

  localparam int USB_CLKS_PER_BIT  = 8;
  localparam int USB_SAMPLE_POINT  = 3;
  localparam int USB_BITS_PER_BYTE = 8;

endpackage : rx_pkg

// File: rtl/sync_flex_counter.sv
// -----------------------------------------------------------------------------
// sync_flex_counter
//   Up-counter that wraps to zero after reaching a programmable rollover
//   value, with synchronous clear and parallel load.
//
//   Priority (highest first): rst, clear, load, count_enable.
//
//   Ports:
//     clk           : clock, rising edge
//     rst           : synchronous active-high reset, count -> 0
//     clear         : synchronous clear, count -> 0
//     count_enable  : advance the count by one (wrapping after rollover_val)
//     load          : load load_val into the count
//     load_val      : value taken on load
//     rollover_val  : last value before the count wraps to zero
//     count         : current count
//     rollover_flag : count currently equals rollover_val
// -----------------------------------------------------------------------------
module sync_flex_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] rollover_val,
  output logic [WIDTH-1:0] count,
  output logic             rollover_flag
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count_enable) begin
      // Wrap explicitly at rollover_val so non-power-of-two periods work.
      if (count == rollover_val) begin
        count <= '0;
      end else begin
        count <= count + WIDTH'(1);
      end
    end
  end

  // Flag is a decode of the current count: it says "the next enabled
  // increment will wrap", which lets users act in the same cycle.
  assign rollover_flag = (count == rollover_val);

endmodule : sync_flex_counter

// File: rtl/rx_bit_timer.sv
// -----------------------------------------------------------------------------
// rx_bit_timer
//   USB receive bit-timing stage. Locks onto bit boundaries reported by the
//   edge detector, emits one sample strobe per bit at a fixed point in the bit
//   window, and counts data bits so a pulse marks every completed byte.
//
//   Ports:
//     clk           : system clock, rising edge
//     rst           : synchronous active-high reset; overrides all inputs
//     d_edge        : one-cycle pulse marking a line transition (bit boundary)
//     rcving        : high while the RX controller is receiving a packet
//     skip_bit      : qualifies shift_enable; current bit is a stuffed bit and
//                     is not counted toward the byte
//     shift_enable  : one-cycle strobe at the bit sample point
//     byte_received : one-cycle pulse the cycle after the last counted bit
//     bit_cnt       : counted bits in the current byte, 0..BITS_PER_BYTE-1
//     dbg           : FSM state and bit-window wrap, for observation only
//
//   Handshake: there is no back-pressure. shift_enable is a single-cycle
//   strobe that downstream logic must consume in the cycle it is asserted;
//   skip_bit is only meaningful in a cycle where shift_enable is high.
//
//   Timing: the cycle carrying d_edge is cycle 0 of the bit, so the first
//   strobe after an edge in cycle N appears in cycle N+SAMPLE_POINT, then
//   every CLKS_PER_BIT cycles until the next edge re-aligns the window.
// -----------------------------------------------------------------------------
module rx_bit_timer
  import rx_pkg::*;
#(
  parameter  int CLKS_PER_BIT  = USB_CLKS_PER_BIT,
  parameter  int SAMPLE_POINT  = USB_SAMPLE_POINT,
  parameter  int BITS_PER_BYTE = USB_BITS_PER_BYTE,
  localparam int CW            = $clog2(CLKS_PER_BIT),
  localparam int BW            = $clog2(BITS_PER_BYTE) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          d_edge,
  input  logic          rcving,
  input  logic          skip_bit,
  output logic          shift_enable,
  output logic          byte_received,
  output logic [BW-1:0] bit_cnt,
  output rx_timer_dbg_t dbg
);

  localparam logic [CW-1:0] CLK_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CLK_SAMPLE = CW'(SAMPLE_POINT);
  localparam logic [CW-1:0] CLK_RESYNC = CW'(1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(BITS_PER_BYTE - 1);

  rx_timer_state_t state;

  logic [CW-1:0] clk_cnt;
  logic          clk_wrap;
  logic          clk_clear;
  logic          clk_load;
  logic          clk_enable;

  logic          bit_clear;
  logic          bit_enable;
  logic          bit_wrap;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          // d_edge is deliberately ignored here: a boundary is only trusted
          // once the controller has declared that a packet is in progress.
          if (rcving) state <= WAIT_EDGE;
        end
        WAIT_EDGE: begin
          if (!rcving)     state <= IDLE;
          else if (d_edge) state <= RUN;
        end
        RUN: begin
          if (!rcving) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sample strobe: pure decode of registered state, so no extra latency. The
  // rcving term suppresses the strobe in the cycle the packet is abandoned.
  // A d_edge arriving exactly at the sample point does not hide the strobe;
  // it only re-aligns the window from the next cycle.
  // ---------------------------------------------------------------------------
  assign shift_enable = (state == RUN) && rcving && (clk_cnt == CLK_SAMPLE);

  // ---------------------------------------------------------------------------
  // Bit-window counter. Held at zero outside RUN unless the edge that starts
  // RUN is present; on any accepted edge it is loaded with 1 because the edge
  // cycle itself is cycle 0. Load beats increment and wrap.
  // ---------------------------------------------------------------------------
  assign clk_clear  = !rcving
                   || (state == IDLE)
                   || ((state == WAIT_EDGE) && !d_edge);
  assign clk_load   = d_edge;
  assign clk_enable = (state == RUN);

  sync_flex_counter #(
    .WIDTH (CW)
  ) u_clk_counter (
    .clk           (clk),
    .rst           (rst),
    .clear         (clk_clear),
    .count_enable  (clk_enable),
    .load          (clk_load),
    .load_val      (CLK_RESYNC),
    .rollover_val  (CLK_LAST),
    .count         (clk_cnt),
    .rollover_flag (clk_wrap)
  );

  // ---------------------------------------------------------------------------
  // Bit counter. Stuffed bits are strobed but not counted. Dropping rcving
  // discards a partial byte.
  // ---------------------------------------------------------------------------
  assign bit_clear  = !rcving || (state == IDLE);
  assign bit_enable = shift_enable && !skip_bit;

  sync_flex_counter #(
    .WIDTH (BW)
  ) u_bit_counter (
    .clk           (clk),
    .rst           (rst),
    .clear         (bit_clear),
    .count_enable  (bit_enable),
    .load          (1'b0),
    .load_val      ('0),
    .rollover_val  (BIT_LAST),
    .count         (bit_cnt),
    .rollover_flag (bit_wrap)
  );

  // ---------------------------------------------------------------------------
  // Byte pulse. Registered from the counted strobe that wraps bit_cnt. Since
  // bit_enable already requires rcving, a packet abort only prevents a pulse
  // that has not yet been registered; one already high still completes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_received <= 1'b0;
    end else begin
      byte_received <= bit_enable && bit_wrap;
    end
  end

  assign dbg.state    = state;
  assign dbg.clk_wrap = clk_wrap;

endmodule : rx_bit_timer
